// File: rtl/sync_w2r_gray.sv
// ----------------------------------------------------------------------------
// sync_w2r_gray
//
// Carries the Gray-coded write pointer of the asynchronous FIFO into the
// read clock domain through a SYNC_STAGES-deep flop chain. The block then
// decodes the synchronised pointer to binary, derives the fill level seen by
// the reader, and emits a one-cycle pulse whenever the decoded pointer moves.
//
// Optional feature macro: SYNC_W2R_GRAY_CHECK_EN
//   When defined, the block watches successive synchronised pointer values.
//   A step that changes more than one bit sets the sticky flag gray_err,
//   which only reset clears. When undefined, gray_err is tied low and no
//   check logic is built. The port stays so the block is a drop-in part.
//
// Parameters
//   DEPTH        FIFO depth, power of two, >= 2
//   SYNC_STAGES  synchroniser flop count, 2..4
//   PTR_W        pointer width, $clog2(DEPTH)+1 (derived)
//
// Ports
//   rclk          in   read-domain clock
//   rrst_n        in   asynchronous active-low reset, already synchronised
//                      to rclk upstream
//   wptr_gray     in   Gray write pointer, registered in the wclk domain
//   rbin          in   binary read pointer, rclk domain
//   rq_wptr_gray  out  synchronised Gray write pointer (last chain stage)
//   rq_wbin       out  registered binary decode of rq_wptr_gray
//   rlevel        out  (rq_wbin - rbin) mod 2^PTR_W, combinational
//   wptr_adv      out  one-cycle pulse on the cycle rq_wbin takes a new value
//   gray_err      out  sticky flag for an illegal multi-bit Gray step
// ----------------------------------------------------------------------------
module sync_w2r_gray #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_W      = $clog2(DEPTH) + 1
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [PTR_W-1:0] wptr_gray,
    input  logic [PTR_W-1:0] rbin,
    output logic [PTR_W-1:0] rq_wptr_gray,
    output logic [PTR_W-1:0] rq_wbin,
    output logic [PTR_W-1:0] rlevel,
    output logic             wptr_adv,
    output logic             gray_err
);

    // Reject an unsupported configuration at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_w2r_gray: SYNC_STAGES must be 2..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_w2r_gray: DEPTH must be a power of two >= 2");
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 0 sits at index 0; the last stage is the synchronised output.
    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_d;
    logic [PTR_W-1:0]                  rq_wbin_q;
    logic [PTR_W-1:0]                  rq_wbin_d;
    logic                              wptr_adv_q;
    logic                              wptr_adv_d;

    // Next state of the synchroniser chain: shift the new sample in at stage 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], wptr_gray};
    end

    // Synchroniser chain register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync_q <= {(SYNC_STAGES * PTR_W){1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rq_wptr_gray = sync_q[SYNC_STAGES-1];

    // Decode the synchronised pointer. The advance pulse registers together
    // with the new binary value, so both show up in the same cycle.
    always_comb begin
        rq_wbin_d  = gray2bin(rq_wptr_gray);
        if (rq_wbin_d != rq_wbin_q) begin
            wptr_adv_d = 1'b1;
        end else begin
            wptr_adv_d = 1'b0;
        end
    end

    // Decoded pointer and advance pulse registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq_wbin_q  <= {PTR_W{1'b0}};
            wptr_adv_q <= 1'b0;
        end else begin
            rq_wbin_q  <= rq_wbin_d;
            wptr_adv_q <= wptr_adv_d;
        end
    end

    assign rq_wbin  = rq_wbin_q;
    assign wptr_adv = wptr_adv_q;

    // The modulo subtract handles pointer wrap without extra logic; the extra
    // MSB of the pointers keeps a full FIFO (level == DEPTH) distinct from empty.
    assign rlevel = rq_wbin_q - rbin;

`ifdef SYNC_W2R_GRAY_CHECK_EN
    localparam int CNT_W = $clog2(PTR_W + 1) + 1;

    // Number of set bits in a pointer-wide vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [PTR_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < PTR_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [PTR_W-1:0] hist_q;
    logic [PTR_W-1:0] hist_d;
    logic             gray_err_q;
    logic             gray_err_d;

    // Compare the synchronised pointer with last cycle's value. Reset puts
    // both at zero, so the first post-reset comparison is always consistent.
    always_comb begin
        hist_d = rq_wptr_gray;
        if (popcount(rq_wptr_gray ^ hist_q) > {{(CNT_W-1){1'b0}}, 1'b1}) begin
            gray_err_d = 1'b1;
        end else begin
            gray_err_d = gray_err_q;
        end
    end

    // History register and sticky error flag.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            hist_q     <= {PTR_W{1'b0}};
            gray_err_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            gray_err_q <= gray_err_d;
        end
    end

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_w2r_gray.sv
// ----------------------------------------------------------------------------
// Bench for sync_w2r_gray. Three instances (SYNC_STAGES 2, 3, 4, DEPTH 8)
// share the same stimulus; each is checked at its own latency.
// ----------------------------------------------------------------------------
module tb_sync_w2r_gray;

`ifdef SYNC_W2R_GRAY_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic            rclk = 1'b0;
    logic            rrst_n;
    logic [3:0]      wptr_gray;
    logic [3:0]      rbin;
    logic [2:0][3:0] q_gray;
    logic [2:0][3:0] q_bin;
    logic [2:0][3:0] lvl;
    logic [2:0]      adv;
    logic [2:0]      err;

    always #5 rclk = ~rclk;

    sync_w2r_gray #(.DEPTH(8), .SYNC_STAGES(2)) dut_s2 (
        .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rbin(rbin),
        .rq_wptr_gray(q_gray[0]), .rq_wbin(q_bin[0]), .rlevel(lvl[0]),
        .wptr_adv(adv[0]), .gray_err(err[0]));

    sync_w2r_gray #(.DEPTH(8), .SYNC_STAGES(3)) dut_s3 (
        .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rbin(rbin),
        .rq_wptr_gray(q_gray[1]), .rq_wbin(q_bin[1]), .rlevel(lvl[1]),
        .wptr_adv(adv[1]), .gray_err(err[1]));

    sync_w2r_gray #(.DEPTH(8), .SYNC_STAGES(4)) dut_s4 (
        .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rbin(rbin),
        .rq_wptr_gray(q_gray[2]), .rq_wbin(q_bin[2]), .rlevel(lvl[2]),
        .wptr_adv(adv[2]), .gray_err(err[2]));

    typedef struct {
        logic [3:0] gray;
        logic [3:0] rbin;
        logic [3:0] exp_bin;
        logic [3:0] exp_lvl;
        logic       exp_adv;
    } vec_t;

    typedef struct {
        int         inst;
        logic [3:0] exp_bin;
        logic [3:0] exp_lvl;
        logic       exp_adv;
        logic       exp_err;
    } sb_t;

    sb_t        sb_q[$];
    vec_t       vt[7];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [3:0] prev_bin;
    logic       err_now;

    task automatic chk(input string name, input int inst,
                       input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (SYNC_STAGES=%0d): got %h expected %h",
                     name, inst + 2, act, exp);
        end
    endtask

    // Drive one step now (caller is away from the clock edge), queue the
    // expected results, then watch six edges and check each instance at
    // exactly its own latency.
    task automatic apply_step(input logic [3:0] g, input logic [3:0] rb,
                              input logic [3:0] eb, input logic [3:0] el,
                              input logic ea, input logic ee);
        sb_t r;
        wptr_gray = g;
        rbin      = rb;
        for (int i = 0; i < 3; i++) begin
            r.inst = i; r.exp_bin = eb; r.exp_lvl = el;
            r.exp_adv = ea; r.exp_err = ee;
            sb_q.push_back(r);
        end
        for (int e = 1; e <= 6; e++) begin
            @(posedge rclk);
            #1;
            for (int i = 0; i < 3; i++) begin
                int ss;
                ss = i + 2;
                if (e <= ss) chk("wptr_adv_idle", i, {3'b000, adv[i]}, 4'b0000);
                if (e == ss) begin
                    chk("rq_wptr_gray", i, q_gray[i], g);
                    chk("rq_wbin_before", i, q_bin[i], prev_bin);
                    chk("gray_err_before", i, {3'b000, err[i]}, {3'b000, err_now});
                end
                if (e == ss + 1) begin
                    r = sb_q.pop_front();
                    chk("sb_order", i, 4'(r.inst), 4'(i));
                    chk("rq_wbin", i, q_bin[i], r.exp_bin);
                    chk("rlevel", i, lvl[i], r.exp_lvl);
                    chk("wptr_adv", i, {3'b000, adv[i]}, {3'b000, r.exp_adv});
                    chk("gray_err", i, {3'b000, err[i]}, {3'b000, r.exp_err});
                end
                if (e == ss + 2) chk("wptr_adv_drop", i, {3'b000, adv[i]}, 4'b0000);
            end
        end
        prev_bin = eb;
        err_now  = ee;
    endtask

    initial begin
        // {gray in, rbin, expected rq_wbin, expected rlevel, expected pulse}
        vt[0] = '{4'b0001, 4'd0,  4'd1,  4'd1,  1'b1};  // single increment
        vt[1] = '{4'b0011, 4'd0,  4'd2,  4'd2,  1'b1};
        vt[2] = '{4'b0011, 4'd1,  4'd2,  4'd1,  1'b0};  // input held, reader moves
        vt[3] = '{4'b0010, 4'd5,  4'd3,  4'd14, 1'b1};  // level > DEPTH, unclamped
        vt[4] = '{4'b1001, 4'd12, 4'd14, 4'd2,  1'b1};  // wrap walk 14, 15, 0
        vt[5] = '{4'b1000, 4'd12, 4'd15, 4'd3,  1'b1};
        vt[6] = '{4'b0000, 4'd12, 4'd0,  4'd4,  1'b1};

        // Reset state, with a non-zero input present.
        rrst_n    = 1'b0;
        wptr_gray = 4'b0101;
        rbin      = 4'd3;
        prev_bin  = 4'd0;
        err_now   = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rq_wptr_gray", i, q_gray[i], 4'b0000);
            chk("rst_rq_wbin", i, q_bin[i], 4'd0);
            chk("rst_wptr_adv", i, {3'b000, adv[i]}, 4'b0000);
            chk("rst_gray_err", i, {3'b000, err[i]}, 4'b0000);
            chk("rst_rlevel", i, lvl[i], 4'd13);
        end
        @(posedge rclk);
        #1;
        rrst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            apply_step(vt[v].gray, vt[v].rbin, vt[v].exp_bin, vt[v].exp_lvl, vt[v].exp_adv, 1'b0);

        // Legal Gray walk from binary 4 up to 13 with the reader at 12.
        for (int b = 4; b <= 13; b++) begin
            logic [3:0] bb;
            bb = 4'(b);
            apply_step(bb ^ (bb >> 1), 4'd12, bb, bb - 4'd12, 1'b1, 1'b0);
        end

        for (int v = 4; v < 7; v++)
            apply_step(vt[v].gray, vt[v].rbin, vt[v].exp_bin, vt[v].exp_lvl, vt[v].exp_adv, 1'b0);

        // Illegal two-bit step 0000 -> 0011, then a legal step: flag is sticky.
        apply_step(4'b0011, 4'd0, 4'd2, 4'd2, 1'b1, CHK);
        apply_step(4'b0010, 4'd0, 4'd3, 4'd3, 1'b1, CHK);

        // Reset while a step is inside the chain.
        wptr_gray = 4'b0001;
        rbin      = 4'd6;
        @(posedge rclk);
        #1;
        rrst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_rq_wptr_gray", i, q_gray[i], 4'b0000);
            chk("midrst_rq_wbin", i, q_bin[i], 4'd0);
            chk("midrst_wptr_adv", i, {3'b000, adv[i]}, 4'b0000);
            chk("midrst_gray_err", i, {3'b000, err[i]}, 4'b0000);
            chk("midrst_rlevel", i, lvl[i], 4'd10);
        end
        repeat (2) @(posedge rclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_hold_adv", i, {3'b000, adv[i]}, 4'b0000);
            chk("midrst_hold_rq_wbin", i, q_bin[i], 4'd0);
        end
        prev_bin = 4'd0;
        err_now  = 1'b0;
        rrst_n   = 1'b1;
        apply_step(4'b0001, 4'd6, 4'd1, 4'd11, 1'b1, 1'b0);

        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
